// File: rtl/vlc_pkg.sv
// Shared VLC definitions: Golomb-Rice decoder state encoding and sizing constants.
package vlc_pkg;
  localparam int unsigned GR_K_W            = 3;
  localparam int unsigned BUF_W             = 64;
  localparam int unsigned LVL_W             = 7;
  localparam int unsigned GRD_MAX_Q_DEFAULT = 28;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREFIX,
    S_SUFFIX,
    S_OUT
  } grd_state_t;
endpackage

// File: rtl/golomb_rice_decode_lzc64.sv
// Leading-zero count over the top i_len bits of a 64-bit left-justified vector,
// saturating at i_len when none of those bits is set.
module lzc64
  import vlc_pkg::*;
(
  input  logic [BUF_W-1:0] i_vec,
  input  logic [LVL_W-1:0] i_len,
  output logic [LVL_W-1:0] o_cnt
);
  logic w_found;

  always_comb begin
    o_cnt   = i_len;
    w_found = 1'b0;
    for (int unsigned i = 0; i < BUF_W; i++) begin
      if (!w_found && (LVL_W'(i) < i_len) && i_vec[6'(BUF_W - 1 - i)]) begin
        o_cnt   = LVL_W'(i);
        w_found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/golomb_rice_decode.sv
// Bit-serial Golomb-Rice decoder: unary prefix, k-bit suffix, optional sign bit,
// fed from a 64-bit left-justified refill buffer.
module golomb_rice_decode
  import vlc_pkg::*;
#(
  parameter int unsigned MAX_Q = GRD_MAX_Q_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [GR_K_W-1:0] cmd_k,
  input  logic              cmd_is_ac_level,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              flush,
  output logic [31:0]       val,
  output logic              is_minus,
  output logic [31:0]       codeword_length,
  output logic              err,
  output logic              out_valid,
  input  logic              out_ready
);
  grd_state_t        r_state, w_state_nxt;
  logic [BUF_W-1:0]  r_buf, w_buf_nxt;
  logic [LVL_W-1:0]  r_lvl, w_lvl_nxt;
  logic [GR_K_W-1:0] r_k, w_k_nxt;
  logic              r_ac, w_ac_nxt;
  logic [31:0]       r_q, w_q_nxt;
  logic [31:0]       r_val, w_val_nxt;
  logic              r_minus, w_minus_nxt;
  logic [31:0]       r_len, w_len_nxt;
  logic              r_err, w_err_nxt;

  logic [LVL_W-1:0]  w_z, w_scan, w_cons, w_rem, w_need;
  logic [31:0]       w_q_scan, w_low;
  logic              w_sign, w_accept;

  lzc64 u_lzc (
    .i_vec (r_buf),
    .i_len (r_lvl),
    .o_cnt (w_z)
  );

  assign in_ready        = (r_lvl <= LVL_W'(32)) && !flush;
  assign cmd_ready       = (r_state == S_IDLE);
  assign out_valid       = (r_state == S_OUT);
  assign val             = r_val;
  assign is_minus        = r_minus;
  assign codeword_length = r_len;
  assign err             = r_err;

  assign w_accept = in_valid && in_ready;
  assign w_need   = LVL_W'(r_k) + LVL_W'(r_ac);
  assign w_scan   = (w_z < r_lvl) ? w_z : r_lvl;
  assign w_q_scan = r_q + 32'(w_scan);
  assign w_low    = (r_k == '0) ? '0 : 32'(r_buf >> (LVL_W'(BUF_W) - LVL_W'(r_k)));
  assign w_sign   = r_buf[6'(BUF_W - 1) - 6'(r_k)];

  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_ac_nxt    = r_ac;
    w_q_nxt     = r_q;
    w_val_nxt   = r_val;
    w_minus_nxt = r_minus;
    w_len_nxt   = r_len;
    w_err_nxt   = r_err;
    w_cons      = '0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_k_nxt     = cmd_k;
          w_ac_nxt    = cmd_is_ac_level;
          w_q_nxt     = '0;
          w_state_nxt = S_PREFIX;
        end
      end
      S_PREFIX: begin
        // Scan covers only zeros; the terminating 1 is consumed only on a legal prefix.
        if (r_lvl != '0) begin
          if (w_q_scan > MAX_Q) begin
            w_cons      = w_scan;
            w_val_nxt   = '0;
            w_minus_nxt = 1'b0;
            w_len_nxt   = w_q_scan;
            w_err_nxt   = 1'b1;
            w_state_nxt = S_OUT;
          end else if (w_z < r_lvl) begin
            w_q_nxt     = w_q_scan;
            w_cons      = w_scan + LVL_W'(1);
            w_state_nxt = S_SUFFIX;
          end else begin
            w_q_nxt = w_q_scan;
            w_cons  = w_scan;
          end
        end
      end
      S_SUFFIX: begin
        if (r_lvl >= w_need) begin
          w_cons      = w_need;
          w_val_nxt   = (r_q << r_k) | w_low;
          w_minus_nxt = r_ac & w_sign;
          w_len_nxt   = r_q + 32'd1 + 32'(w_need);
          w_err_nxt   = 1'b0;
          w_state_nxt = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Refill lands right behind whatever survives this cycle's consumption.
  assign w_rem     = r_lvl - w_cons;
  assign w_buf_nxt = (r_buf << w_cons) | (w_accept ? ({in_data, 32'h0} >> w_rem) : '0);
  assign w_lvl_nxt = w_rem + (w_accept ? LVL_W'(32) : '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_buf   <= '0;
      r_lvl   <= '0;
      r_k     <= '0;
      r_ac    <= 1'b0;
      r_q     <= '0;
      r_val   <= '0;
      r_minus <= 1'b0;
      r_len   <= '0;
      r_err   <= 1'b0;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_buf   <= '0;
      r_lvl   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_buf   <= w_buf_nxt;
      r_lvl   <= w_lvl_nxt;
      r_k     <= w_k_nxt;
      r_ac    <= w_ac_nxt;
      r_q     <= w_q_nxt;
      r_val   <= w_val_nxt;
      r_minus <= w_minus_nxt;
      r_len   <= w_len_nxt;
      r_err   <= w_err_nxt;
    end
  end
endmodule

// File: tb/tb_golomb_rice_decode.sv
// Self-checking bench for golomb_rice_decode: bit-queue reference decoder plus
// directed literal expectations and an encoded random stream.
module tb_golomb_rice_decode;
  import vlc_pkg::*;

  typedef struct {
    logic [31:0] val;
    logic        minus;
    logic [31:0] len;
    logic        err;
    bit          chk_len;
  } exp_t;

  logic        clk, reset, flush;
  logic [31:0] in_data;
  logic        in_valid, in_ready;
  logic [2:0]  cmd_k;
  logic        cmd_is_ac_level, cmd_valid, cmd_ready;
  logic [31:0] val, codeword_length;
  logic        is_minus, err, out_valid, out_ready;

  logic [31:0] b_in_data, b_val, b_len;
  logic        b_in_valid, b_in_ready, b_cmd_ac, b_cmd_valid, b_cmd_ready;
  logic [2:0]  b_cmd_k;
  logic        b_minus, b_err, b_out_valid, b_out_ready;

  int          checks = 0;
  int          failures = 0;
  bit          mbits[$];
  logic [31:0] feed_q[$];
  exp_t        exp_q[$];
  exp_t        cmp_e;
  bit          rand_gap = 0, rand_ready = 0, ready_force = 1, fhs;

  golomb_rice_decode dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .cmd_k(cmd_k), .cmd_is_ac_level(cmd_is_ac_level), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .flush(flush), .val(val), .is_minus(is_minus), .codeword_length(codeword_length),
    .err(err), .out_valid(out_valid), .out_ready(out_ready)
  );

  golomb_rice_decode #(.MAX_Q(63)) dut63 (
    .clk(clk), .reset(reset), .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .cmd_k(b_cmd_k), .cmd_is_ac_level(b_cmd_ac), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
    .flush(1'b0), .val(b_val), .is_minus(b_minus), .codeword_length(b_len),
    .err(b_err), .out_valid(b_out_valid), .out_ready(b_out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, expv);
    end
  endtask

  // Reference decoder: walks the stream as a plain bit queue.
  function automatic exp_t model_decode(input int unsigned k, input bit ac, input int unsigned maxq);
    exp_t e;
    int unsigned q = 0;
    int unsigned low = 0;
    bit s = 1'b0;
    e = '{val: '0, minus: 1'b0, len: '0, err: 1'b0, chk_len: 1'b0};
    while (mbits.size() > 0 && mbits[0] == 1'b0 && q <= maxq) begin
      void'(mbits.pop_front());
      q++;
    end
    if (q > maxq) begin
      e.err = 1'b1;
      return e;
    end
    void'(mbits.pop_front());
    for (int unsigned i = 0; i < k; i++) low = low * 2 + 32'(mbits.pop_front());
    if (ac) s = mbits.pop_front();
    e.val     = q * (32'd1 << k) + low;
    e.minus   = s;
    e.len     = q + 1 + k + 32'(ac);
    e.chk_len = 1'b1;
    return e;
  endfunction

  task automatic push_word(input logic [31:0] w);
    feed_q.push_back(w);
    for (int i = 31; i >= 0; i--) mbits.push_back(w[i]);
  endtask

  // Word feeder with optional random in_valid gaps.
  initial begin
    in_valid = 1'b0;
    in_data  = '0;
    forever begin
      @(negedge clk);
      fhs = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (fhs && feed_q.size() > 0) void'(feed_q.pop_front());
      if (feed_q.size() > 0 && (!rand_gap || $urandom_range(0, 3) != 0)) begin
        in_valid = 1'b1;
        in_data  = feed_q[0];
      end else begin
        in_valid = 1'b0;
        in_data  = '0;
      end
    end
  end

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
    end
  end

  // Every cycle a result is presented it must match the head of the expectation queue.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL out_unexpected: got val=%0d len=%0d err=%0d expected no result", val, codeword_length, err);
      end else begin
        cmp_e = exp_q[0];
        if (cmp_e.err ? (err !== 1'b1 || val !== 32'd0 || is_minus !== 1'b0)
                      : (err !== 1'b0 || val !== cmp_e.val || is_minus !== cmp_e.minus ||
                         (cmp_e.chk_len && codeword_length !== cmp_e.len))) begin
          failures++;
          $display("FAIL out_cmp: got val=%0d minus=%0d len=%0d err=%0d expected val=%0d minus=%0d len=%0d err=%0d",
                   val, is_minus, codeword_length, err, cmp_e.val, cmp_e.minus, cmp_e.len, cmp_e.err);
        end
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic issue_cmd(input logic [2:0] k, input logic ac, input exp_t e, input bit keep);
    bit acc = 1'b0;
    cmd_k = k;
    cmd_is_ac_level = ac;
    cmd_valid = 1'b1;
    for (int i = 0; i < 400 && !acc; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        acc = 1'b1;
        if (keep) exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL cmd_timeout: got cmd_ready=0 expected 1 within 400 cycles");
    end
  endtask

  task automatic wait_out(input string nm, input logic [31:0] v, input logic m,
                          input logic [31:0] l, input logic e);
    bit got = 1'b0;
    for (int i = 0; i < 150 && !got; i++) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1'b1;
        check({nm, "_val"}, val, v);
        check({nm, "_minus"}, 32'(is_minus), 32'(m));
        check({nm, "_len"}, codeword_length, l);
        check({nm, "_err"}, 32'(err), 32'(e));
      end
      @(posedge clk);
      #1;
    end
    if (!got) check({nm, "_timeout"}, 32'(out_valid), 32'd1);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    feed_q.delete();
    mbits.delete();
    @(negedge clk);
    check("flush_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_lvl", 32'(dut.r_lvl), 32'd0);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_idle", 32'(dut.r_state == S_IDLE), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 3000 && exp_q.size() > 0; i++) @(posedge clk);
    #1;
    check(nm, 32'(exp_q.size()), 32'd0);
  endtask

  // Encodes n random codewords and issues their commands; the tuple is the expectation.
  task automatic random_stream(input int n, input int issue_n);
    bit enc[$];
    logic [2:0] ks[$];
    bit acs[$];
    exp_t es[$];
    exp_t em;
    logic [31:0] w;
    for (int c = 0; c < n; c++) begin
      int unsigned k, q, low;
      bit ac, s;
      exp_t e;
      k = $urandom_range(0, 7);
      q = $urandom_range(0, 20);
      low = $urandom & ((32'd1 << k) - 1);
      ac = 1'($urandom_range(0, 1));
      s = ac ? 1'($urandom_range(0, 1)) : 1'b0;
      repeat (q) enc.push_back(1'b0);
      enc.push_back(1'b1);
      for (int i = int'(k) - 1; i >= 0; i--) enc.push_back(low[i]);
      if (ac) enc.push_back(s);
      e = '{val: q * (32'd1 << k) + low, minus: s, len: q + 1 + k + 32'(ac), err: 1'b0, chk_len: 1'b1};
      ks.push_back(3'(k));
      acs.push_back(ac);
      es.push_back(e);
    end
    while (enc.size() > 0) begin
      w = '0;
      for (int i = 0; i < 32; i++) w = {w[30:0], (enc.size() > 0) ? enc.pop_front() : 1'b0};
      push_word(w);
    end
    for (int c = 0; c < issue_n; c++) begin
      em = model_decode(ks[c], acs[c], 28);
      check("model_vs_encoder_val", em.val, es[c].val);
      issue_cmd(ks[c], acs[c], es[c], 1'b1);
    end
  endtask

  initial begin
    exp_t e;
    int cyc;
    reset = 1'b1;
    flush = 1'b0;
    cmd_valid = 1'b0;
    cmd_k = '0;
    cmd_is_ac_level = 1'b0;
    b_in_valid = 1'b0;
    b_in_data = '0;
    b_cmd_valid = 1'b0;
    b_cmd_k = '0;
    b_cmd_ac = 1'b0;
    b_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_val", val, 32'd0);
    check("rst_len", codeword_length, 32'd0);
    check("rst_err_minus", {30'd0, err, is_minus}, 32'd0);
    check("rst_lvl", 32'(dut.r_lvl), 32'd0);
    @(posedge clk);
    #1;

    // Pin the reference decoder to hand-computed values.
    push_word(32'h1400_0000);
    e = model_decode(2, 1'b0, 28);
    check("model_a_val", e.val, 32'd13);
    check("model_a_len", e.len, 32'd6);
    mbits.delete();
    push_word(32'h3000_0000);
    e = model_decode(0, 1'b1, 28);
    check("model_b_val", e.val, 32'd2);
    check("model_b_minus", 32'(e.minus), 32'd1);
    check("model_b_len", e.len, 32'd4);
    mbits.delete();
    feed_q.delete();

    // Prefix spanning a refill on the MAX_Q=63 instance.
    b_in_valid = 1'b1; b_in_data = 32'h0; b_cmd_valid = 1'b1; b_cmd_k = 3'd1; b_out_ready = 1'b1;
    @(negedge clk);
    check("span_ready", {30'd0, b_in_ready, b_cmd_ready}, 32'd3);
    @(posedge clk);
    #1;
    b_cmd_valid = 1'b0;
    b_in_data = 32'h0001_0000;
    @(negedge clk);
    check("span_in_ready2", 32'(b_in_ready), 32'd1);
    @(posedge clk);
    #1;
    b_in_valid = 1'b0;
    cyc = 0;
    for (int c = 2; c < 40 && cyc == 0; c++) begin
      @(negedge clk);
      if (b_out_valid) begin
        cyc = c;
        check("span_val", b_val, 32'd94);
        check("span_len", b_len, 32'd49);
        check("span_minus_err", {30'd0, b_err, b_minus}, 32'd0);
      end
      @(posedge clk);
      #1;
    end
    check("span_latency", 32'(cyc), 32'd4);
    @(negedge clk);
    check("span_lvl_after", 32'(dut63.r_lvl), 32'd15);
    @(posedge clk);
    #1;

    // Basic decodes.
    push_word(32'h1400_0000);
    issue_cmd(3'd2, 1'b0, model_decode(2, 1'b0, 28), 1'b1);
    wait_out("k2", 32'd13, 1'b0, 32'd6, 1'b0);
    @(negedge clk);
    check("k2_lvl_after", 32'(dut.r_lvl), 32'd26);
    @(posedge clk);
    #1;
    do_flush();
    push_word(32'h3000_0000);
    issue_cmd(3'd0, 1'b1, model_decode(0, 1'b1, 28), 1'b1);
    wait_out("k0ac", 32'd2, 1'b1, 32'd4, 1'b0);
    do_flush();

    // Prefix overflow, then recovery after flush.
    push_word(32'h0000_0000);
    push_word(32'h8000_0000);
    issue_cmd(3'd0, 1'b0, model_decode(0, 1'b0, 28), 1'b1);
    wait_out("ovf", 32'd0, 1'b0, 32'd32, 1'b1);
    do_flush();
    push_word(32'h1400_0000);
    issue_cmd(3'd2, 1'b0, model_decode(2, 1'b0, 28), 1'b1);
    wait_out("recover", 32'd13, 1'b0, 32'd6, 1'b0);
    do_flush();

    // Output backpressure holds the result and blocks new commands.
    ready_force = 1'b0;
    push_word(32'h3000_0000);
    issue_cmd(3'd0, 1'b1, model_decode(0, 1'b1, 28), 1'b1);
    wait_out("bp", 32'd2, 1'b1, 32'd4, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_val", {val[29:0], is_minus, cmd_ready}, {30'd2, 1'b1, 1'b0});
      check("bp_hold_len", codeword_length, 32'd4);
      @(posedge clk);
      #1;
    end
    ready_force = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("bp_released", 32'(exp_q.size()), 32'd0);
    do_flush();

    // Flush while starved in SUFFIX: q=28 leaves 3 bits, k=3 plus sign needs 4.
    push_word(32'h0000_0008);
    e = '{val: '0, minus: 1'b0, len: '0, err: 1'b0, chk_len: 1'b0};
    issue_cmd(3'd3, 1'b1, e, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("suffix_stall", 32'(dut.r_state == S_SUFFIX), 32'd1);
    @(posedge clk);
    #1;
    do_flush();
    check("flush_cmd_ready", 32'(cmd_ready), 32'd1);

    // Random stream with input and output gaps.
    rand_gap = 1'b1;
    rand_ready = 1'b1;
    random_stream(40, 40);
    drain("rand_drain");
    do_flush();

    // Reset in the middle of a stream.
    random_stream(12, 4);
    reset = 1'b1;
    feed_q.delete();
    mbits.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    rand_gap = 1'b0;
    rand_ready = 1'b0;
    @(negedge clk);
    check("midrst_val", val, 32'd0);
    check("midrst_len", codeword_length, 32'd0);
    check("midrst_flags", {28'd0, out_valid, err, is_minus, 1'b0}, 32'd0);
    check("midrst_ready", {30'd0, in_ready, cmd_ready}, 32'd3);
    check("midrst_lvl", 32'(dut.r_lvl), 32'd0);
    @(posedge clk);
    #1;
    push_word(32'h1400_0000);
    issue_cmd(3'd2, 1'b0, model_decode(2, 1'b0, 28), 1'b1);
    wait_out("after_rst", 32'd13, 1'b0, 32'd6, 1'b0);
    drain("final_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish before time limit");
    $fatal(1, "timeout");
  end
endmodule
